// File: rtl/l1_stream_out_pkg.sv
// Shared constants and types for the L1 streaming stage and its sibling layers.
package l1_stream_out_pkg;
    localparam int L1_W     = 32;
    localparam int L1_WORDS = L1_W * L1_W;
    localparam int L0_WORDS = 4096;
    localparam int DW       = 20;

    localparam logic [2:0] CSEL_L0 = 3'd1;
    localparam logic [2:0] CSEL_L1 = 3'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO: dout always shows the head entry while !empty.
module sync_fifo_fwft #(
    parameter int DW    = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage is cleared too so the head reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/l1_stream_out.sv
// Reads the finished L1 map sequentially and emits it as a valid/ready stream,
// tracking the frame maximum and pulsing done after the last accepted beat.
module l1_stream_out #(
    parameter int          N_WORDS    = l1_stream_out_pkg::L1_WORDS,
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DW         = l1_stream_out_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mrd,
    output logic [11:0]   maddr,
    input  logic [DW-1:0] mdata_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [9:0]    m_idx,
    output logic          m_last,
    output logic [DW-1:0] frame_max
);
    import l1_stream_out_pkg::*;

    localparam int IW = $clog2(N_WORDS + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state, state_nxt;
    logic [IW-1:0] issue_cnt;
    logic [9:0]    acc_cnt;
    logic          rd_q, hs, issue_ok;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   outstanding;

    assign m_valid = !fifo_empty;
    assign hs      = m_valid && m_ready;
    assign m_idx   = acc_cnt;
    assign m_last  = (acc_cnt == 10'(N_WORDS - 1)) && m_valid;

    // A credit is held from issue until pop: the read on the bus (mrd) and the
    // one returning (rd_q) both count, so a push can never find the FIFO full.
    always_comb begin
        outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, mrd} + {{CW{1'b0}}, rd_q};
        issue_ok    = (state == ST_RUN) && (issue_cnt < IW'(N_WORDS)) &&
                      (outstanding < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mrd       <= 1'b0;
            maddr     <= '0;
            issue_cnt <= '0;
            rd_q      <= 1'b0;
            acc_cnt   <= '0;
            frame_max <= '0;
        end else begin
            rd_q <= mrd;
            if (state == ST_IDLE && start) begin
                mrd       <= 1'b1;
                maddr     <= BASE_ADDR;
                issue_cnt <= IW'(1);
                acc_cnt   <= '0;
                frame_max <= '0;
            end else begin
                mrd <= issue_ok;
                if (issue_ok) begin
                    maddr     <= BASE_ADDR + 12'(issue_cnt);
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (hs) begin
                    acc_cnt <= acc_cnt + 1'b1;
                    if (m_data > frame_max) frame_max <= m_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (hs && m_last) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_FIN);
    end

    sync_fifo_fwft #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_q),
        .pop   (hs),
        .din   (mdata_rd),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(rd_q && fifo_full && !hs));
endmodule

// File: tb/tb_l1_stream_out.sv
// Self-checking bench: memory models, a frame driver that records the stream,
// and per-scenario tasks comparing it with a reference derived from memory contents.
module tb_l1_stream_out;
    localparam int DW = 20;
    localparam int NW = 1024;

    logic clk = 1'b0, reset = 1'b1;
    logic start = 1'b0, m_ready = 1'b0;
    logic busy, done, mrd, m_valid, m_last;
    logic [11:0] maddr;
    logic [DW-1:0] mdata_rd = '0, m_data, frame_max;
    logic [9:0] m_idx;

    logic start2 = 1'b0, m_ready2 = 1'b0;
    logic busy2, done2, mrd2, m_valid2, m_last2;
    logic [11:0] maddr2;
    logic [DW-1:0] mdata_rd2 = '0, m_data2, frame_max2;
    logic [9:0] m_idx2;

    logic [DW-1:0] mem  [0:4095];
    logic [DW-1:0] mem2 [0:4095];

    int tot = 0, bad = 0;
    logic [DW-1:0] q_data[$];
    int q_idx[$];
    bit q_last[$];
    int done_k, done_cnt, mrd_early, unstable, first_valid_k, first_mrd_k;
    logic [11:0] first_maddr;
    logic [DW-1:0] snap_data, fmax_k1;
    logic [9:0] snap_idx;
    logic snap_valid;
    logic [2:0] rst_snap;

    always #5 clk = ~clk;

    always @(posedge clk) if (mrd) mdata_rd <= mem[maddr];
    always @(posedge clk) if (mrd2) mdata_rd2 <= mem2[maddr2];

    l1_stream_out u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mrd(mrd), .maddr(maddr), .mdata_rd(mdata_rd), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
        .frame_max(frame_max)
    );

    l1_stream_out #(.BASE_ADDR(12'h400)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .mrd(mrd2), .maddr(maddr2), .mdata_rd(mdata_rd2), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_data(m_data2), .m_idx(m_idx2), .m_last(m_last2),
        .frame_max(frame_max2)
    );

    // Expected frame is simply memory words base..base+NW-1 (mod 4096) in order.
    function automatic int seq_errs(input logic [11:0] base);
        int e = 0;
        logic [11:0] a;
        if (q_data.size() != NW) e++;
        for (int i = 0; i < q_data.size(); i++) begin
            a = base + 12'(i);
            if (q_data[i] !== mem[a]) e++;
            if (q_idx[i] != i) e++;
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] ref_max(input logic [11:0] base);
        logic [DW-1:0] mx = '0;
        logic [11:0] a;
        for (int i = 0; i < NW; i++) begin
            a = base + 12'(i);
            if (mem[a] > mx) mx = mem[a];
        end
        return mx;
    endfunction

    function automatic int last_count();
        int n = 0;
        foreach (q_last[i]) if (q_last[i]) n++;
        return n;
    endfunction

    // Called at a negedge. k counts edges after the start edge; values seen at
    // negedge k are those sampled by the design at edge k.
    task automatic run_frame(input int rmode, input int max_cyc, input int xbeat, input int rbeat);
        logic pv, pr;
        logic [DW-1:0] pd;
        logic [9:0] pi;
        int stop_at;
        bit xdone;
        q_data.delete(); q_idx.delete(); q_last.delete();
        done_k = 0; done_cnt = 0; mrd_early = 0; unstable = 0;
        first_valid_k = 0; first_mrd_k = 0; first_maddr = '0; rst_snap = '1;
        pv = 1'b0; pr = 1'b0; pd = '0; pi = '0; stop_at = 0; xdone = 1'b0;
        m_ready = (rmode == 0);
        start = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) fmax_k1 = frame_max;
            if (mrd && first_mrd_k == 0) begin first_mrd_k = k; first_maddr = maddr; end
            if (m_valid && first_valid_k == 0) first_valid_k = k;
            if (k <= 20 && mrd) mrd_early++;
            if (k == 20) begin snap_data = m_data; snap_idx = m_idx; snap_valid = m_valid; end
            if (pv && !pr && (!m_valid || m_data !== pd || m_idx !== pi)) unstable++;
            if (done) begin done_cnt++; if (done_k == 0) done_k = k; end
            if (!xdone && xbeat >= 0 && q_data.size() == xbeat) begin start = 1'b1; xdone = 1'b1; end
            if (rbeat >= 0 && q_data.size() == rbeat && stop_at == 0) begin
                reset = 1'b1;
                #1;
                rst_snap = {m_valid, busy, mrd};
                stop_at = k + 12;
                pv = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                m_ready = 1'b0;
                continue;
            end
            case (rmode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = (k > 20);
                default: m_ready = 1'b1;
            endcase
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_idx.push_back(int'(m_idx));
                q_last.push_back(m_last);
            end
            pv = m_valid; pr = m_ready; pd = m_data; pi = m_idx;
            if (done_k != 0 && k >= done_k + 3) break;
            if (stop_at != 0 && k >= stop_at) break;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tot++;
        if ({busy, done, mrd, m_valid, m_last} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, mrd, m_valid, m_last});
        end
        tot++;
        if ({maddr, m_data, m_idx, frame_max} !== '0) begin
            bad++; $display("FAIL reset_data maddr=%0h data=%0h idx=%0d max=%0h want all 0", maddr, m_data, m_idx, frame_max);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a + 5);
        run_frame(0, 1200, -1, -1);
        tot++; if (first_mrd_k != 1 || first_maddr !== 12'h000) begin
            bad++; $display("FAIL basic_first_read k=%0d addr=%0h want k=1 addr=0", first_mrd_k, first_maddr); end
        tot++; if (first_valid_k != 3) begin
            bad++; $display("FAIL basic_first_valid got=%0d want=3", first_valid_k); end
        tot++; if (q_data.size() != NW) begin
            bad++; $display("FAIL basic_beats got=%0d want=%0d", q_data.size(), NW); end
        tot++; if (seq_errs(12'h000) != 0) begin
            bad++; $display("FAIL basic_sequence errors=%0d want=0", seq_errs(12'h000)); end
        tot++; if (q_data[0] !== 20'd5 || q_data[NW-1] !== 20'd1028) begin
            bad++; $display("FAIL basic_endpoints first=%0d last=%0d want 5 1028", q_data[0], q_data[NW-1]); end
        tot++; if (last_count() != 1 || !q_last[NW-1]) begin
            bad++; $display("FAIL basic_m_last count=%0d want=1 on final beat", last_count()); end
        tot++; if (done_k != NW + 3 || done_cnt != 1) begin
            bad++; $display("FAIL basic_done cycle=%0d pulses=%0d want %0d 1", done_k, done_cnt, NW + 3); end
        tot++; if (frame_max !== 20'd1028) begin
            bad++; $display("FAIL basic_frame_max got=%0d want=1028", frame_max); end
    endtask

    task automatic test_backpressure();
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a + 5);
        run_frame(2, 1400, -1, -1);
        tot++; if (mrd_early != 4) begin
            bad++; $display("FAIL bp_reads_outstanding got=%0d want=4", mrd_early); end
        tot++; if ({snap_valid, snap_data, snap_idx} !== {1'b1, 20'd5, 10'd0}) begin
            bad++; $display("FAIL bp_hold valid=%0b data=%0d idx=%0d want 1 5 0", snap_valid, snap_data, snap_idx); end
        tot++; if (unstable != 0) begin
            bad++; $display("FAIL bp_stable changes=%0d want=0", unstable); end
        tot++; if (seq_errs(12'h000) != 0 || done_cnt != 1) begin
            bad++; $display("FAIL bp_sequence errors=%0d done=%0d want 0 1", seq_errs(12'h000), done_cnt); end
    endtask

    task automatic test_random();
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        run_frame(1, 4000, -1, -1);
        tot++; if (seq_errs(12'h000) != 0) begin
            bad++; $display("FAIL rand_sequence errors=%0d want=0", seq_errs(12'h000)); end
        tot++; if (frame_max !== ref_max(12'h000)) begin
            bad++; $display("FAIL rand_frame_max got=%0h want=%0h", frame_max, ref_max(12'h000)); end
        tot++; if (unstable != 0 || done_cnt != 1) begin
            bad++; $display("FAIL rand_stable_done changes=%0d done=%0d want 0 1", unstable, done_cnt); end
    endtask

    task automatic test_restart();
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a + 5);
        run_frame(0, 1200, 100, -1);
        tot++; if (done_cnt != 1 || q_data.size() != NW) begin
            bad++; $display("FAIL restart_ignored done=%0d beats=%0d want 1 %0d", done_cnt, q_data.size(), NW); end
        tot++; if (done_k != NW + 3 || seq_errs(12'h000) != 0) begin
            bad++; $display("FAIL restart_frame done_k=%0d errors=%0d want %0d 0", done_k, seq_errs(12'h000), NW + 3); end
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a % 16);
        @(negedge clk);
        run_frame(0, 1200, -1, -1);
        tot++; if (fmax_k1 !== '0) begin
            bad++; $display("FAIL restart_max_clear got=%0h want=0", fmax_k1); end
        tot++; if (frame_max !== 20'd15 || frame_max !== ref_max(12'h000)) begin
            bad++; $display("FAIL restart_frame_max got=%0d want=15", frame_max); end
        tot++; if (done_cnt != 1 || seq_errs(12'h000) != 0) begin
            bad++; $display("FAIL restart_second done=%0d errors=%0d want 1 0", done_cnt, seq_errs(12'h000)); end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        run_frame(0, 1200, -1, 500);
        tot++; if (rst_snap !== 3'b000) begin
            bad++; $display("FAIL midrst_outputs valid_busy_mrd=%b want=000", rst_snap); end
        tot++; if (done_cnt != 0 || q_data.size() != 500) begin
            bad++; $display("FAIL midrst_no_done done=%0d beats=%0d want 0 500", done_cnt, q_data.size()); end
        tot++; if (frame_max !== '0) begin
            bad++; $display("FAIL midrst_max got=%0h want=0", frame_max); end
        run_frame(0, 1200, -1, -1);
        tot++; if (q_idx[0] != 0 || seq_errs(12'h000) != 0) begin
            bad++; $display("FAIL midrst_restream idx0=%0d errors=%0d want 0 0", q_idx[0], seq_errs(12'h000)); end
        tot++; if (done_cnt != 1 || done_k != NW + 3) begin
            bad++; $display("FAIL midrst_done pulses=%0d cycle=%0d want 1 %0d", done_cnt, done_k, NW + 3); end
    endtask

    task automatic test_base_addr();
        logic [11:0] fa;
        logic [DW-1:0] d777;
        int beats, seen_done;
        for (int a = 0; a < 4096; a++) mem2[a] = '0;
        mem2[12'h400 + 12'd777] = 20'hFFFFF;
        fa = '0; d777 = '0; beats = 0; seen_done = 0;
        m_ready2 = 1'b1;
        start2 = 1'b1;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (mrd2 && k == 1) fa = maddr2;
            if (m_valid2 && m_ready2) begin
                if (beats == 777) d777 = m_data2;
                beats++;
            end
            if (done2) begin seen_done = 1; break; end
        end
        m_ready2 = 1'b0;
        tot++; if (fa !== 12'h400) begin
            bad++; $display("FAIL base_first_addr got=%0h want=400", fa); end
        tot++; if (beats != NW || seen_done != 1) begin
            bad++; $display("FAIL base_beats got=%0d done=%0d want %0d 1", beats, seen_done, NW); end
        tot++; if (d777 !== 20'hFFFFF || frame_max2 !== 20'hFFFFF) begin
            bad++; $display("FAIL base_unsigned_max word777=%0h max=%0h want fffff", d777, frame_max2); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_restart();
        test_reset_mid();
        test_base_addr();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
